// File: rtl/dbg_pkg.sv
// Shared constants and FSM encoding for the debug snapshot sequencer.
// Optional feature macro used by this slice: DBG_SNAP_DBLBUF_EN (double-buffered snapshot).
package dbg_pkg;

  localparam int DBG_WORDS = 128;
  localparam int FCNT_W    = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } dbg_state_e;

endpackage

// File: rtl/dbg_snap_ram.sv
// Snapshot RAM: one write port, one registered read port.
// With DBG_SNAP_DBLBUF_EN defined, a bank-select bit extends both addresses.
module dbg_snap_ram
  import dbg_pkg::*;
#(
  parameter int ADDR_W = $clog2(DBG_WORDS),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
`ifdef DBG_SNAP_DBLBUF_EN
  input  logic              wbank,
  input  logic              rbank,
`endif
  output logic [DATA_W-1:0] rdata
);

`ifdef DBG_SNAP_DBLBUF_EN
  localparam int MEM_AW = ADDR_W + 1;
  logic [MEM_AW-1:0] wa;
  logic [MEM_AW-1:0] ra;
  assign wa = {wbank, waddr};
  assign ra = {rbank, raddr};
`else
  localparam int MEM_AW = ADDR_W;
  logic [MEM_AW-1:0] wa;
  logic [MEM_AW-1:0] ra;
  assign wa = waddr;
  assign ra = raddr;
`endif

  logic [DATA_W-1:0] mem [2**MEM_AW];

  // NOTE: the array itself is never reset; only the read register is, so it still maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdata;
  end

  // Read-before-write on a same-address collision in single-bank builds.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[ra];
  end

endmodule

// File: rtl/dbg_snap_ctrl.sv
// Debug snapshot sequencer: walks every debug address once per frame into a shadow RAM.
// DBG_SNAP_DBLBUF_EN selects double buffering with an atomic bank swap at DONE.
module dbg_snap_ctrl
  import dbg_pkg::*;
#(
  parameter int ADDR_W = $clog2(DBG_WORDS),
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              freeze,
  input  logic              ovr_clr,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  dbg_state_e                     state;
  logic [1:0]                     drain_cnt;
  logic [RD_LAT-1:0]              pipe_vld;
  logic [RD_LAT-1:0][ADDR_W-1:0]  pipe_idx;
  logic                           wr_en;
`ifdef DBG_SNAP_DBLBUF_EN
  logic                           bank_sel;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dbg_addr  <= '0;
      drain_cnt <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      pipe_vld  <= '0;
`ifdef DBG_SNAP_DBLBUF_EN
      bank_sel  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (frame_start && !freeze) state <= ISSUE;
        end
        ISSUE: begin
          if (dbg_addr == ADDR_LAST) begin
            state     <= DRAIN;
            dbg_addr  <= '0;
            drain_cnt <= '0;
          end else begin
            dbg_addr <= dbg_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= DONE;
          else                         drain_cnt <= drain_cnt + 2'd1;
        end
        DONE: begin
          state     <= IDLE;
          frame_cnt <= frame_cnt + FCNT_W'(1);
`ifdef DBG_SNAP_DBLBUF_EN
          bank_sel  <= ~bank_sel;
`endif
        end
        default: state <= IDLE;
      endcase

      // A late frame_start is only reported; setting takes priority over clearing.
      if (frame_start && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)                 overrun <= 1'b0;

      pipe_vld[0] <= (state == ISSUE);
      for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Index tags travel alongside the valid bits; they need no reset.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= dbg_addr;
    for (int i = 1; i < RD_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
  end

  // A reset cycle drops whatever write is at the head of the pipeline.
  assign wr_en = pipe_vld[RD_LAT-1] & ~rst;

  dbg_snap_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (pipe_idx[RD_LAT-1]),
    .wdata (dbg_data),
    .raddr (disp_addr),
`ifdef DBG_SNAP_DBLBUF_EN
    .wbank (~bank_sel),
    .rbank (bank_sel),
`endif
    .rdata (disp_data)
  );

endmodule
